// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS types, period states and fixed control/guard-band symbols.
package tmds_pkg;

    typedef logic [9:0] tmds_sym_t;

    typedef enum logic [1:0] {
        ST_CTRL,
        ST_PREAMBLE,
        ST_GUARD,
        ST_VIDEO
    } tmds_state_t;

    localparam tmds_sym_t TOK_00   = 10'b1101010100;
    localparam tmds_sym_t TOK_01   = 10'b0010101011;
    localparam tmds_sym_t TOK_10   = 10'b0101010100;
    localparam tmds_sym_t TOK_11   = 10'b1010101011;

    localparam tmds_sym_t GUARD_02 = 10'b1011001100;
    localparam tmds_sym_t GUARD_1  = 10'b0100110011;

endpackage

// File: rtl/tmds_channel_ctrl_token.sv
// tmds_ctl_token: maps the two control bits (C1,C0) to their 10-bit TMDS control token.
module tmds_ctl_token
    import tmds_pkg::*;
(
    input  logic [1:0] ctl_i,
    output tmds_sym_t  tok_o
);

    assign tok_o = ctl_i[1] ? (ctl_i[0] ? TOK_11 : TOK_10)
                            : (ctl_i[0] ? TOK_01 : TOK_00);

endmodule

// File: rtl/tmds_channel_ctrl.sv
// tmds_channel_ctrl: per-channel TMDS period sequencer driving encoder load/s_rst and the output mux.
// TMDS_GUARD_BAND_EN adds the HDMI preamble and leading guard band; without it the block runs in DVI mode.
module tmds_channel_ctrl
    import tmds_pkg::*;
#(
    parameter int CH_ID        = 0,
    parameter int MIN_CTRL     = 12,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       vid_req,
    input  logic       pix_valid,
    input  logic [1:0] ctl,
    input  logic [9:0] enc_in,
    output logic       pix_ready,
    output logic       enc_load,
    output logic       enc_srst,
    output logic [9:0] tmds_out
);

    localparam int MAX_PG = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int MAX_P  = (MIN_CTRL > MAX_PG) ? MIN_CTRL : MAX_PG;
    localparam int CNT_W  = $clog2(MAX_P + 1);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CTRL);
    localparam tmds_sym_t GUARD_SYM = (CH_ID == 1) ? GUARD_1 : GUARD_02;

    tmds_state_t      state_q, state_d;
    logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
    tmds_sym_t        tmds_q, tmds_d, tok;

`ifdef TMDS_GUARD_BAND_EN
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_LEN - 1);
    logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
`endif

    tmds_ctl_token u_tok (
        .ctl_i (ctl),
        .tok_o (tok)
    );

    assign pix_ready = (state_q == ST_VIDEO);
    assign enc_load  = pix_valid & pix_ready;
    assign enc_srst  = ~pix_ready;
    assign tmds_out  = tmds_q;

    always_comb begin
        state_d    = state_q;
        ctrl_cnt_d = ctrl_cnt_q;
`ifdef TMDS_GUARD_BAND_EN
        ph_cnt_d   = ph_cnt_q;
`endif
        tmds_d     = (state_q == ST_GUARD) ? GUARD_SYM : tok;
        case (state_q)
            ST_CTRL: begin
                ctrl_cnt_d = (ctrl_cnt_q == MIN_C) ? MIN_C : ctrl_cnt_q + 1'b1;
                if (vid_req && ctrl_cnt_q == MIN_C) begin
`ifdef TMDS_GUARD_BAND_EN
                    state_d  = ST_PREAMBLE;
                    ph_cnt_d = '0;
`else
                    state_d  = ST_VIDEO;
`endif
                end
            end
`ifdef TMDS_GUARD_BAND_EN
            // vid_req is deliberately ignored here: a started preamble always completes
            ST_PREAMBLE: begin
                ph_cnt_d = (ph_cnt_q == PRE_LAST) ? '0 : ph_cnt_q + 1'b1;
                state_d  = (ph_cnt_q == PRE_LAST) ? ST_GUARD : ST_PREAMBLE;
            end
            ST_GUARD: begin
                ph_cnt_d = (ph_cnt_q == GRD_LAST) ? '0 : ph_cnt_q + 1'b1;
                state_d  = (ph_cnt_q == GRD_LAST) ? ST_VIDEO : ST_GUARD;
            end
`endif
            ST_VIDEO: begin
                if (pix_valid) begin
                    tmds_d = enc_in;
                end else begin
                    state_d    = ST_CTRL;
                    ctrl_cnt_d = CNT_W'(1);
                end
            end
            default: state_d = ST_CTRL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_CTRL;
            ctrl_cnt_q <= '0;
            tmds_q     <= TOK_00;
`ifdef TMDS_GUARD_BAND_EN
            ph_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            tmds_q     <= tmds_d;
`ifdef TMDS_GUARD_BAND_EN
            ph_cnt_q   <= ph_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tmds_channel_ctrl.sv
// tb_tmds_channel_ctrl: directed and randomized checks of tmds_channel_ctrl against a period-level model.
module tb_tmds_channel_ctrl;

    localparam int MIN = 12;
    localparam int PRE = 8;
    localparam int GRD = 2;
`ifdef TMDS_GUARD_BAND_EN
    localparam bit HDMI = 1'b1;
    localparam int CH   = 0;
`else
    localparam bit HDMI = 1'b0;
    localparam int CH   = 1;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       vid_req = 1'b0;
    logic       pix_valid = 1'b0;
    logic [1:0] ctl = 2'b00;
    logic [9:0] enc_in = '0;
    logic       pix_ready, enc_load, enc_srst;
    logic [9:0] tmds_out;

    always #5 clk = ~clk;

    tmds_channel_ctrl #(
        .CH_ID        (CH),
        .MIN_CTRL     (MIN),
        .PREAMBLE_LEN (PRE),
        .GUARD_LEN    (GRD)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .vid_req   (vid_req),
        .pix_valid (pix_valid),
        .ctl       (ctl),
        .enc_in    (enc_in),
        .pix_ready (pix_ready),
        .enc_load  (enc_load),
        .enc_srst  (enc_srst),
        .tmds_out  (tmds_out)
    );

    logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] px [4]      = '{10'h155, 10'h2AA, 10'h0FF, 10'h300};
    logic [9:0] guard_w     = (CH == 1) ? 10'h133 : 10'h2CC;

    int vectors = 0;
    int miscompares = 0;

    // model: cycles spent in control, cycles left in preamble/guard, in-video flag
    int         m_ctl_len, m_pre, m_grd;
    bit         m_vid;
    logic [9:0] exp_tmds;
    bit         ready_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctl_len = 0;
        m_pre     = 0;
        m_grd     = 0;
        m_vid     = 1'b0;
        exp_tmds  = 10'h354;
    endtask

    task automatic step(input bit vr, input bit pv, input logic [1:0] c, input logic [9:0] e);
        vid_req   = vr;
        pix_valid = pv;
        ctl       = c;
        enc_in    = e;
        #1;
        chk("pix_ready", 32'(pix_ready), 32'(m_vid));
        chk("enc_load", 32'(enc_load), 32'(m_vid & pv));
        chk("enc_srst", 32'(enc_srst), 32'(!m_vid));
        ready_seen = pix_ready;
        if (m_vid) exp_tmds = pv ? e : tok_tab[c];
        else if (m_pre == 0 && m_grd > 0) exp_tmds = guard_w;
        else exp_tmds = tok_tab[c];
        if (m_vid) begin
            if (!pv) begin
                m_vid     = 1'b0;
                m_ctl_len = 1;
            end
        end else if (m_pre > 0) begin
            m_pre--;
        end else if (m_grd > 0) begin
            m_grd--;
            if (m_grd == 0) m_vid = 1'b1;
        end else if (vr && m_ctl_len >= MIN) begin
            if (HDMI) begin
                m_pre = PRE;
                m_grd = GRD;
            end else begin
                m_vid = 1'b1;
            end
        end else begin
            m_ctl_len++;
        end
        @(posedge clk);
        #1;
        chk("tmds_out", 32'(tmds_out), 32'(exp_tmds));
    endtask

    initial begin
        int n;
        model_reset();
        pix_valid = 1'b1;
        #1 n_rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_tmds", 32'(tmds_out), 32'h354);
        chk("rst_ready", 32'(pix_ready), 32'd0);
        chk("rst_load", 32'(enc_load), 32'd0);
        chk("rst_srst", 32'(enc_srst), 32'd1);
        n_rst = 1'b1;

        // hold vid_req from reset; first slot must appear at the computed interval
        n = 0;
        ready_seen = 1'b0;
        while (!ready_seen && n < 40) begin
            step(1'b1, 1'b1, 2'b01, px[0]);
            n++;
        end
        chk("first_ready_interval", 32'(n - 1), HDMI ? 32'd23 : 32'd13);
        chk("pixel_out", 32'(tmds_out), 32'h155);
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 1'b1, 2'b01, px[i]);
            chk("pixel_out", 32'(tmds_out), 32'(px[i]));
        end

        // end of period, then re-acceptance only after the control minimum
        step(1'b1, 1'b0, 2'b11, 10'h000);
        chk("end_token", 32'(tmds_out), 32'h2AB);
        n = 0;
        ready_seen = 1'b0;
        while (!ready_seen && n < 60) begin
            step(1'b1, 1'b1, 2'b11, 10'($urandom));
            n++;
        end
        chk("reaccept_gap", 32'(n), HDMI ? 32'd23 : 32'd13);

        // request withdrawn right after acceptance; zero-pixel video period
        step(1'b0, 1'b0, 2'b00, 10'h000);
        repeat (14) step(1'b0, 1'b0, 2'($urandom), 10'($urandom));
        step(1'b1, 1'b0, 2'b10, 10'h000);
        n = 1;
        ready_seen = 1'b0;
        while (!ready_seen && n < 40) begin
            step(1'b0, 1'b0, 2'b10, 10'($urandom));
            n++;
        end
        chk("withdrawn_req_ready", 32'(n), HDMI ? 32'd12 : 32'd2);
        step(1'b0, 1'b0, 2'b00, 10'h000);

        // asynchronous reset in the middle of video
        n = 0;
        ready_seen = 1'b0;
        while (!ready_seen && n < 40) begin
            step(1'b1, 1'b1, 2'b01, 10'($urandom));
            n++;
        end
        chk("video_before_reset", 32'(ready_seen), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("async_rst_tmds", 32'(tmds_out), 32'h354);
        chk("async_rst_ready", 32'(pix_ready), 32'd0);
        chk("async_rst_load", 32'(enc_load), 32'd0);
        chk("async_rst_srst", 32'(enc_srst), 32'd1);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_reset();

        repeat (3000) begin
            bit vr, pv;
            vr = ($urandom_range(0, 3) != 0);
            pv = m_vid ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
            step(vr, pv, 2'($urandom), 10'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
